// File: rtl/taus_urng.sv
`default_nettype none
// ============================================================================
// Module   : taus_urng
// Purpose  : Two lock-stepped taus88 generators feeding the Box-Muller seed
//            words a/b, with runtime seeding, warm-up and valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
module taus_urng #(
    parameter int          WARMUP  = 8,
    parameter logic [31:0] SEED_A1 = 32'h1234_5678,
    parameter logic [31:0] SEED_A2 = 32'h2345_6789,
    parameter logic [31:0] SEED_A3 = 32'h3456_789A,
    parameter logic [31:0] SEED_B1 = 32'h4567_89AB,
    parameter logic [31:0] SEED_B2 = 32'h5678_9ABC,
    parameter logic [31:0] SEED_B3 = 32'h6789_ABCD
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        seed_valid,
    input  logic [31:0] seed_data,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int                CNT_W      = $clog2(WARMUP + 1);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [2:0]        c_idx_last = 3'd5;

    typedef enum logic [1:0] {
        S_WARM = 2'd0,
        S_RUN  = 2'd1,
        S_SEED = 2'd2
    } state_t;

    state_t           r_state, w_state_ns;
    logic [CNT_W-1:0] r_cnt, w_cnt_ns;
    logic [2:0]       r_idx, w_idx_ns;
    logic             w_valid_ns;
    logic             w_step;
    logic             w_wr;
    logic [2:0]       w_wr_idx;
    logic [31:0]      w_seed_word;
    // Word order: A.s1, A.s2, A.s3, B.s1, B.s2, B.s3
    logic [31:0]      r_s [0:5];
    logic [31:0]      w_s_nx [0:5];
    logic [31:0]      w_a_nx, w_b_nx;

    function automatic logic [31:0] f_step1(input logic [31:0] s);
        logic [31:0] t;
        t = ((s << 13) ^ s) >> 19;
        return ((s & 32'hFFFF_FFFE) << 12) ^ t;
    endfunction

    function automatic logic [31:0] f_step2(input logic [31:0] s);
        logic [31:0] t;
        t = ((s << 2) ^ s) >> 25;
        return ((s & 32'hFFFF_FFF8) << 4) ^ t;
    endfunction

    function automatic logic [31:0] f_step3(input logic [31:0] s);
        logic [31:0] t;
        t = ((s << 3) ^ s) >> 11;
        return ((s & 32'hFFFF_FFF0) << 17) ^ t;
    endfunction

    function automatic logic [31:0] f_default(input logic [2:0] idx);
        case (idx)
            3'd0:    return SEED_A1;
            3'd1:    return SEED_A2;
            3'd2:    return SEED_A3;
            3'd3:    return SEED_B1;
            3'd4:    return SEED_B2;
            default: return SEED_B3;
        endcase
    endfunction

    // Smallest legal value per word; anything below would lock that component at zero
    function automatic logic [31:0] f_min(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd3: return 32'd2;
            3'd1, 3'd4: return 32'd8;
            default:    return 32'd16;
        endcase
    endfunction

    always_comb begin
        w_s_nx[0] = f_step1(r_s[0]);
        w_s_nx[1] = f_step2(r_s[1]);
        w_s_nx[2] = f_step3(r_s[2]);
        w_s_nx[3] = f_step1(r_s[3]);
        w_s_nx[4] = f_step2(r_s[4]);
        w_s_nx[5] = f_step3(r_s[5]);
        w_a_nx    = w_s_nx[0] ^ w_s_nx[1] ^ w_s_nx[2];
        w_b_nx    = w_s_nx[3] ^ w_s_nx[4] ^ w_s_nx[5];
    end

    assign w_seed_word = (seed_data < f_min(w_wr_idx)) ? f_default(w_wr_idx) : seed_data;

    always_comb begin
        w_state_ns = r_state;
        w_cnt_ns   = r_cnt;
        w_idx_ns   = r_idx;
        w_valid_ns = out_valid;
        w_step     = 1'b0;
        w_wr       = 1'b0;
        w_wr_idx   = r_idx;
        case (r_state)
            S_WARM, S_RUN: begin
                if (seed_valid) begin
                    // Reseed wins over a pending transfer; the held pair is dropped
                    w_wr       = 1'b1;
                    w_wr_idx   = 3'd0;
                    w_idx_ns   = 3'd1;
                    w_valid_ns = 1'b0;
                    w_state_ns = S_SEED;
                end else if (r_state == S_WARM) begin
                    w_step = 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_ns   = '0;
                        w_valid_ns = 1'b1;
                        w_state_ns = S_RUN;
                    end else begin
                        w_cnt_ns = r_cnt + c_cnt_one;
                    end
                end else if (out_ready) begin
                    w_step = 1'b1;
                end
            end
            S_SEED: begin
                if (seed_valid) begin
                    w_wr = 1'b1;
                    if (r_idx == c_idx_last) begin
                        w_idx_ns   = 3'd0;
                        w_cnt_ns   = '0;
                        w_state_ns = S_WARM;
                    end else begin
                        w_idx_ns = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_ns = S_WARM;
                w_cnt_ns   = '0;
                w_idx_ns   = 3'd0;
                w_valid_ns = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_WARM;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            out_valid <= 1'b0;
            a         <= 32'd0;
            b         <= 32'd0;
            for (int i = 0; i < 6; i++) begin
                r_s[i] <= f_default(3'(i));
            end
        end else begin
            r_state   <= w_state_ns;
            r_cnt     <= w_cnt_ns;
            r_idx     <= w_idx_ns;
            out_valid <= w_valid_ns;
            if (w_step) begin
                for (int i = 0; i < 6; i++) begin
                    r_s[i] <= w_s_nx[i];
                end
                a <= w_a_nx;
                b <= w_b_nx;
            end else if (w_wr) begin
                r_s[w_wr_idx] <= w_seed_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_taus_urng.sv
`default_nettype none
// ============================================================================
// Module   : tb_taus_urng
// Purpose  : Directed self-checking bench for taus_urng.
// Revision : 1.0  initial release
// ============================================================================
module tb_taus_urng;

    logic        clk = 1'b0;
    logic        resetn;
    logic        seed_valid;
    logic [31:0] seed_data;
    logic        out_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] a2, b2;
    logic        out_valid2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ms [0:5];
    logic [31:0] ea, eb;

    always #5 clk = ~clk;

    // Small-seed instance: WARMUP=1 and every default equal to the minimum word
    taus_urng #(
        .WARMUP (1),
        .SEED_A1(32'd2), .SEED_A2(32'd8), .SEED_A3(32'd16),
        .SEED_B1(32'd2), .SEED_B2(32'd8), .SEED_B3(32'd16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .seed_valid(seed_valid),
        .seed_data (seed_data),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    taus_urng dut2 (
        .clk       (clk),
        .resetn    (resetn),
        .seed_valid(1'b0),
        .seed_data (32'd0),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (1'b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m1(input logic [31:0] s);
        return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction
    function automatic logic [31:0] m2(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction
    function automatic logic [31:0] m3(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    task automatic m_adv();
        ms[0] = m1(ms[0]); ms[1] = m2(ms[1]); ms[2] = m3(ms[2]);
        ms[3] = m1(ms[3]); ms[4] = m2(ms[4]); ms[5] = m3(ms[5]);
        ea = ms[0] ^ ms[1] ^ ms[2];
        eb = ms[3] ^ ms[4] ^ ms[5];
    endtask

    task automatic m_load(input logic [31:0] w0, w1, w2, w3, w4, w5);
        ms[0] = w0; ms[1] = w1; ms[2] = w2; ms[3] = w3; ms[4] = w4; ms[5] = w5;
    endtask

    task automatic send_seeds(input logic [31:0] w [6], input int gap);
        for (int i = 0; i < 6; i++) begin
            seed_valid = 1'b1;
            seed_data  = w[i];
            tick();
            seed_valid = 1'b0;
            seed_data  = 32'd0;
            if (i == 0) check("seed_first_valid", {31'd0, out_valid}, 32'd0);
            if (i < 5) begin
                repeat (gap) tick();
                if (i == 2) check("seed_gap_valid", {31'd0, out_valid}, 32'd0);
            end
        end
        check("seed_last_valid", {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] w_small [6]  = '{32'd2, 32'd8, 32'd16, 32'd2, 32'd8, 32'd16};
    logic [31:0] w_zero  [6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] w_below [6]  = '{32'd1, 32'd7, 32'd15, 32'd1, 32'd7, 32'd15};
    logic [31:0] w_mix   [6]  = '{32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h0BAD_F00D,
                                  32'h1357_9BDF, 32'h2468_ACE0, 32'hFEDC_BA98};

    int ones_a [32];
    int ones_b [32];
    int n_acc;
    int bad_a, bad_b;
    logic xfer;

    initial begin
        resetn     = 1'b0;
        seed_valid = 1'b0;
        seed_data  = 32'd0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_a", a, 32'd0);
        check("rst_b", b, 32'd0);
        check("rst_valid2", {31'd0, out_valid2}, 32'd0);

        // Release: WARMUP=1 instance valid after one edge, default instance after eight
        resetn = 1'b1;
        tick();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_a", a, 32'h0020_2080);
        check("first_b", b, 32'h0020_2080);
        check("dut2_valid_e1", {31'd0, out_valid2}, 32'd0);
        repeat (6) tick();
        check("dut2_valid_e7", {31'd0, out_valid2}, 32'd0);
        check("hold_a_7", a, 32'h0020_2080);
        tick();
        m_load(32'h1234_5678, 32'h2345_6789, 32'h3456_789A,
               32'h4567_89AB, 32'h5678_9ABC, 32'h6789_ABCD);
        repeat (8) m_adv();
        check("dut2_valid_e8", {31'd0, out_valid2}, 32'd1);
        check("dut2_a", a2, ea);
        check("dut2_b", b2, eb);

        out_ready = 1'b1;
        tick();
        check("second_a", a, 32'h0200_2C80);
        check("second_b", b, 32'h0200_2C80);

        // Continue with the model, then apply 5 cycles of backpressure
        m_load(32'd2, 32'd8, 32'd16, 32'd2, 32'd8, 32'd16);
        m_adv();
        m_adv();
        for (int i = 0; i < 3; i++) begin
            tick();
            m_adv();
            check("run_a", a, ea);
            check("run_b", b, eb);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_a", a, ea);
            check("bp_b", b, eb);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        m_adv();
        check("resume_a", a, ea);
        check("resume_b", b, eb);

        // Reseed with idle gaps
        send_seeds(w_small, 2);
        tick();
        check("reseed_valid", {31'd0, out_valid}, 32'd1);
        check("reseed_a", a, 32'h0020_2080);
        check("reseed_b", b, 32'h0020_2080);

        // All-zero words fall back to defaults
        send_seeds(w_zero, 0);
        tick();
        check("zero_a1", a, 32'h0020_2080);
        check("zero_b1", b, 32'h0020_2080);
        tick();
        check("zero_a2", a, 32'h0200_2C80);
        check("zero_b2", b, 32'h0200_2C80);

        // One below each minimum also falls back
        send_seeds(w_below, 1);
        tick();
        check("below_a", a, 32'h0020_2080);
        check("below_b", b, 32'h0020_2080);

        // Reset after three words: partial seed discarded
        for (int i = 0; i < 3; i++) begin
            seed_valid = 1'b1;
            seed_data  = w_mix[i];
            tick();
        end
        seed_valid = 1'b0;
        resetn     = 1'b0;
        tick();
        check("midseed_rst_valid", {31'd0, out_valid}, 32'd0);
        check("midseed_rst_a", a, 32'd0);
        resetn = 1'b1;
        tick();
        check("midseed_valid", {31'd0, out_valid}, 32'd1);
        check("midseed_a", a, 32'h0020_2080);
        check("midseed_b", b, 32'h0020_2080);

        // Arbitrary full seed, then a long run with random backpressure
        send_seeds(w_mix, 0);
        tick();
        m_load(w_mix[0], w_mix[1], w_mix[2], w_mix[3], w_mix[4], w_mix[5]);
        m_adv();
        check("mix_valid", {31'd0, out_valid}, 32'd1);
        check("mix_a", a, ea);
        check("mix_b", b, eb);

        n_acc = 0;
        for (int k = 0; k < 32; k++) begin
            ones_a[k] = 0;
            ones_b[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            xfer      = out_valid & out_ready;
            tick();
            if (xfer) begin
                m_adv();
                n_acc++;
                for (int k = 0; k < 32; k++) begin
                    ones_a[k] += int'(a[k]);
                    ones_b[k] += int'(b[k]);
                end
            end
            check("long_a", a, ea);
            check("long_b", b, eb);
        end
        bad_a = 0;
        bad_b = 0;
        for (int k = 0; k < 32; k++) begin
            if (ones_a[k] * 100 < n_acc * 45 || ones_a[k] * 100 > n_acc * 55) bad_a++;
            if (ones_b[k] * 100 < n_acc * 45 || ones_b[k] * 100 > n_acc * 55) bad_b++;
        end
        check("density_a_bad_bits", 32'(bad_a), 32'd0);
        check("density_b_bad_bits", 32'(bad_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
